// File: rtl/counter_pkg.sv
// Shared types and limits for the parametrised up/down counter family.
package counter_pkg;

    localparam int unsigned COUNTER_MIN_WIDTH = 2;

    typedef enum logic {
        MODE_WRAP,
        MODE_SATURATE
    } count_mode_e;

endpackage

// File: rtl/updown_counter.sv
// Parametrised up/down counter with runtime modulus, wrap/saturate mode and
// a registered terminal-count pulse. Define UPDOWN_COUNTER_OVF_EN for a sticky boundary flag.
module updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             up,
    input  logic [WIDTH-1:0] max_val,
    input  count_mode_e      mode,
`ifdef UPDOWN_COUNTER_OVF_EN
    input  logic             ovf_clr,
    output logic             ovf_sticky,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    if (WIDTH < COUNTER_MIN_WIDTH) begin : g_width_chk
        $error("updown_counter: WIDTH must be at least %0d", COUNTER_MIN_WIDTH);
    end

    logic [WIDTH-1:0] count_d, count_q;
    logic             tc_d, tc_q;
    logic             at_bound;

    // Next count and boundary detection; >= lets out-of-range loads fall back into range.
    always_comb begin
        count_d  = count_q;
        tc_d     = 1'b0;
        at_bound = 1'b0;
        if (load) begin
            count_d = load_data;
        end else if (en) begin
            if (up) begin
                at_bound = (count_q >= max_val);
                if (at_bound) begin
                    count_d = (mode == MODE_SATURATE) ? max_val : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                at_bound = (count_q == '0);
                if (at_bound) begin
                    count_d = (mode == MODE_SATURATE) ? '0 : max_val;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            tc_d = at_bound;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

`ifdef UPDOWN_COUNTER_OVF_EN
    logic ovf_d, ovf_q;

    // A boundary step in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (at_bound) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_sticky = ovf_q;
`endif

endmodule
